// File: rtl/modport_apb_slave_pkg.sv
// modport_apb_pkg: shared FSM state type, default bus widths and address-to-word-index helper
package modport_apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int IDX_W          = 64;

    // Full (untruncated) word index of a byte address; callers range-check or wrap it
    function automatic logic [IDX_W-1:0] addr_to_index(input logic [IDX_W-1:0] paddr);
        return paddr >> 2;
    endfunction

endpackage

// File: rtl/modport_apb_slave_if.sv
// modport_apb_slave_if: APB3 bus bundle
//   master modport drives PSEL1/PENABLE/PWRITE/PADDR/PWDATA, receives PRDATA/PREADY/PSLVERR
//   slave modport is the mirror image
interface modport_apb_slave_if
    import modport_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  PSEL1;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/modport_apb_slave_regfile.sv
// apb_regfile: MEM_DEPTH x DATA_WIDTH register file, synchronous write, combinational read
//   clk/rst (async, active-high clear), we/waddr/wdata write port, raddr/rdata read port
module apb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/modport_apb_slave.sv
// modport_apb_slave: APB3 completer with word-addressed register file and programmable wait states
//   clk, PRESET (async, active-high), bus (modport_apb_slave_if.slave)
//   Optional APB_SLVERR_EN: misaligned / out-of-range accesses answer PSLVERR=1 and are
//   not committed; without it PADDR[1:0] is ignored and the word index wraps modulo MEM_DEPTH.
module modport_apb_slave
    import modport_apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input logic                clk,
    input logic                PRESET,
    modport_apb_slave_if.slave bus
);

    localparam int IW = $clog2(MEM_DEPTH);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t                state, state_n;
    logic [IW-1:0]         idx_q, idx_n;
    logic                  wr_q, wr_n;
    logic                  err_q, err_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic                  pready_q, pready_n;
    logic                  pslverr_q, pslverr_n;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_n;

    logic [IDX_W-1:0]      full_idx;
    logic [IW-1:0]         idx_in, rd_idx;
    logic                  err_in, err_use, wr_use, we;
    logic [DATA_WIDTH-1:0] rd_word, resp;
    logic                  unused_bits;

    assign full_idx = addr_to_index(IDX_W'(bus.PADDR));
    assign idx_in   = full_idx[IW-1:0];

`ifdef APB_SLVERR_EN
    assign err_in = (bus.PADDR[1:0] != 2'b00) || (full_idx >= IDX_W'(MEM_DEPTH));
`else
    assign err_in = 1'b0;
`endif

    assign unused_bits = ^{full_idx[IDX_W-1:IW], bus.PADDR[1:0]};

    // A zero-wait response is formed at the setup edge, before the request is latched,
    // so the read index and error flag come straight from the bus in IDLE.
    assign rd_idx  = (state == IDLE) ? idx_in : idx_q;
    assign err_use = (state == IDLE) ? err_in : err_q;
    assign wr_use  = (state == IDLE) ? bus.PWRITE : wr_q;
    assign resp    = (!wr_use && !err_use) ? rd_word : '0;

    assign we = (state != IDLE) && bus.PSEL1 && bus.PENABLE && pready_q && wr_q && !err_q;

    apb_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_WIDTH (IW)
    ) u_regfile (
        .clk  (clk),
        .rst  (PRESET),
        .we   (we),
        .waddr(idx_q),
        .wdata(wdata_q),
        .raddr(rd_idx),
        .rdata(rd_word)
    );

    always_comb begin
        state_n   = state;
        idx_n     = idx_q;
        wr_n      = wr_q;
        err_n     = err_q;
        wdata_n   = wdata_q;
        cnt_n     = cnt_q;
        pready_n  = pready_q;
        pslverr_n = pslverr_q;
        prdata_n  = prdata_q;
        if (state == IDLE) begin
            if (bus.PSEL1 && !bus.PENABLE) begin
                state_n = SETUP;
                idx_n   = idx_in;
                wr_n    = bus.PWRITE;
                err_n   = err_in;
                wdata_n = bus.PWDATA;
                cnt_n   = CW'(WAIT_CYCLES);
                if (WAIT_CYCLES == 0) begin
                    pready_n  = 1'b1;
                    pslverr_n = err_in;
                    prdata_n  = resp;
                end
            end
        end else if (!bus.PSEL1 || (bus.PENABLE && pready_q)) begin
            // abort or completion: single-cycle response, back to IDLE
            state_n   = IDLE;
            pready_n  = 1'b0;
            pslverr_n = 1'b0;
            prdata_n  = '0;
        end else if (bus.PENABLE) begin
            state_n = ACCESS;
            cnt_n   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                pready_n  = 1'b1;
                pslverr_n = err_use;
                prdata_n  = resp;
            end
        end
    end

    always_ff @(posedge clk or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state     <= state_n;
            idx_q     <= idx_n;
            wr_q      <= wr_n;
            err_q     <= err_n;
            wdata_q   <= wdata_n;
            cnt_q     <= cnt_n;
            pready_q  <= pready_n;
            pslverr_q <= pslverr_n;
            prdata_q  <= prdata_n;
        end
    end

    assign bus.PRDATA  = prdata_q;
    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_modport_apb_slave.sv
// tb_modport_apb_slave: randomized self-checking bench over three completers (0, 1 and 3 wait states)
module tb_modport_apb_slave;

    logic        clk = 1'b0;
    logic        preset;
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int errors = 0;
    int checks = 0;
    logic [31:0] model [3][256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        modport_apb_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.PSEL1   = psel[g];
        assign bus.PENABLE = penable[g];
        assign bus.PWRITE  = pwrite[g];
        assign bus.PADDR   = paddr[g];
        assign bus.PWDATA  = pwdata[g];
        assign prdata[g]   = bus.PRDATA;
        assign pready[g]   = bus.PREADY;
        assign pslverr[g]  = bus.PSLVERR;
        modport_apb_slave #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_DEPTH  (256),
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) dut (
            .clk   (clk),
            .PRESET(preset),
            .bus   (bus)
        );
    end

    function automatic int wait_of(input int d);
        return d == 0 ? 0 : (d == 1 ? 1 : 3);
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a >> 2) % 256);
    endfunction

    function automatic logic ref_err(input logic [31:0] a);
`ifdef APB_SLVERR_EN
        return (a % 4 != 0) || ((a >> 2) >= 256);
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 256; i++)
                model[d][i] = '0;
    endtask

    // One APB transfer; starts driving the setup phase immediately and returns at the
    // negedge after the completion edge, so consecutive calls run back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic se, output int waits, output logic after);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        @(posedge clk); #1 penable[d] = 1'b1;
        waits = 0; rd = '0; se = 1'b0; after = 1'b1;
        while (1) begin
            @(negedge clk);
            if (pready[d] === 1'b1) break;
            waits++;
            if (waits > 20) begin
                errors++;
                $display("FAIL pready_timeout dut%0d addr %h: no PREADY within 20 cycles", d, a);
                psel[d] = 1'b0; penable[d] = 1'b0;
                return;
            end
            @(posedge clk); #1 paddr[d] = $urandom; pwdata[d] = $urandom;
        end
        rd = prdata[d]; se = pslverr[d];
        @(posedge clk); #1 psel[d] = 1'b0; penable[d] = 1'b0;
        @(negedge clk); after = pready[d];
    endtask

    task automatic test_reset();
        preset = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++; if (pready[d] !== 1'b0) begin errors++; $display("FAIL reset_pready dut%0d got %b want 0", d, pready[d]); end
            checks++; if (pslverr[d] !== 1'b0) begin errors++; $display("FAIL reset_pslverr dut%0d got %b want 0", d, pslverr[d]); end
            checks++; if (prdata[d] !== 32'h0) begin errors++; $display("FAIL reset_prdata dut%0d got %h want 0", d, prdata[d]); end
        end
        @(posedge clk); #1 preset = 1'b0;
        clear_model();
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic se, af; int w;
        xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, rd, se, w, af);
        model[1][4] = 32'hDEADBEEF;
        checks++; if (w !== 1) begin errors++; $display("FAIL basic_wr_waits got %0d want 1", w); end
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL basic_wr_slverr got %b want 0", se); end
        checks++; if (af !== 1'b0) begin errors++; $display("FAIL basic_wr_pulse got %b want 0", af); end
        xfer(1, 1'b0, 32'h10, 32'h0, rd, se, w, af);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data got %h want deadbeef", rd); end
        checks++; if (w !== 1) begin errors++; $display("FAIL basic_rd_waits got %0d want 1", w); end
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL basic_rd_slverr got %b want 0", se); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic se, af; int w;
        logic [31:0] exp_d [2];
        exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222;
        for (int i = 0; i < 2; i++) begin
            xfer(0, 1'b1, 32'(i * 4), exp_d[i], rd, se, w, af);
            model[0][i] = exp_d[i];
            checks++; if (w !== 0) begin errors++; $display("FAIL zw_wr_waits%0d got %0d want 0", i, w); end
        end
        for (int i = 0; i < 2; i++) begin
            xfer(0, 1'b0, 32'(i * 4), 32'h0, rd, se, w, af);
            checks++; if (w !== 0) begin errors++; $display("FAIL zw_rd_waits%0d got %0d want 0", i, w); end
            checks++; if (rd !== exp_d[i]) begin errors++; $display("FAIL zw_rd_data%0d got %h want %h", i, rd, exp_d[i]); end
            checks++; if (af !== 1'b0) begin errors++; $display("FAIL zw_pulse%0d got %b want 0", i, af); end
        end
    endtask

    task automatic test_wait3();
        logic [31:0] rd, v; logic se, af; int w;
        v = $urandom;
        xfer(2, 1'b1, 32'h24, v, rd, se, w, af);
        model[2][9] = v;
        xfer(2, 1'b0, 32'h24, 32'h0, rd, se, w, af);
        checks++; if (w !== 3) begin errors++; $display("FAIL w3_waits got %0d want 3", w); end
        checks++; if (rd !== v) begin errors++; $display("FAIL w3_data got %h want %h", rd, v); end
        checks++; if (af !== 1'b0) begin errors++; $display("FAIL w3_pulse got %b want 0", af); end
    endtask

    task automatic test_error();
        logic [31:0] rd; logic se, af; int w;
        logic [31:0] addrs [2];
        addrs[0] = 32'h400; addrs[1] = 32'h2;
        for (int i = 0; i < 2; i++) begin
            xfer(1, 1'b1, addrs[i], 32'hA5A5A5A5, rd, se, w, af);
            if (!ref_err(addrs[i])) model[1][ref_idx(addrs[i])] = 32'hA5A5A5A5;
            checks++; if (se !== ref_err(addrs[i])) begin errors++; $display("FAIL err_wr_slverr%0d got %b want %b", i, se, ref_err(addrs[i])); end
            xfer(1, 1'b0, 32'h0, 32'h0, rd, se, w, af);
            checks++; if (rd !== model[1][0]) begin errors++; $display("FAIL err_mem0_%0d got %h want %h", i, rd, model[1][0]); end
            xfer(1, 1'b0, addrs[i], 32'h0, rd, se, w, af);
            checks++; if (se !== ref_err(addrs[i])) begin errors++; $display("FAIL err_rd_slverr%0d got %b want %b", i, se, ref_err(addrs[i])); end
            checks++; if (rd !== (ref_err(addrs[i]) ? 32'h0 : model[1][ref_idx(addrs[i])])) begin
                errors++; $display("FAIL err_rd_data%0d got %h", i, rd);
            end
        end
    endtask

    task automatic test_idle_penable();
        logic [31:0] rd; logic se, af; int w, highs;
        highs = 0;
        psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h10; pwdata[1] = 32'h0BADF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (pready[1] === 1'b1) highs++;
        end
        psel[1] = 1'b0; penable[1] = 1'b0;
        checks++; if (highs !== 0) begin errors++; $display("FAIL idle_penable_pready got %0d highs want 0", highs); end
        xfer(1, 1'b0, 32'h10, 32'h0, rd, se, w, af);
        checks++; if (rd !== model[1][4]) begin errors++; $display("FAIL idle_penable_data got %h want %h", rd, model[1][4]); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic se, af; int w, highs;
        highs = 0;
        @(posedge clk); #1;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h20; pwdata[2] = 32'hCAFEF00D;
        @(posedge clk); #1 penable[2] = 1'b1;
        @(posedge clk); #1 psel[2] = 1'b0; penable[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (pready[2] === 1'b1) highs++;
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL abort_pready got %0d highs want 0", highs); end
        xfer(2, 1'b0, 32'h20, 32'h0, rd, se, w, af);
        checks++; if (rd !== model[2][8]) begin errors++; $display("FAIL abort_data got %h want %h", rd, model[2][8]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, v, exp_rd; logic se, af, wr, e; int w, d;
        for (int n = 0; n < 90; n++) begin
            d  = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 15) * 4) : 32'($urandom_range(0, 2047));
            v  = $urandom;
            e  = ref_err(a);
            exp_rd = (wr || e) ? 32'h0 : model[d][ref_idx(a)];
            xfer(d, wr, a, v, rd, se, w, af);
            if (wr && !e) model[d][ref_idx(a)] = v;
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_data n%0d dut%0d addr %h got %h want %h", n, d, a, rd, exp_rd); end
            checks++; if (se !== e) begin errors++; $display("FAIL rnd_slverr n%0d dut%0d addr %h got %b want %b", n, d, a, se, e); end
            checks++; if (w !== wait_of(d)) begin errors++; $display("FAIL rnd_waits n%0d dut%0d got %0d want %0d", n, d, w, wait_of(d)); end
            checks++; if (af !== 1'b0) begin errors++; $display("FAIL rnd_pulse n%0d dut%0d got %b want 0", n, d, af); end
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic se, af; int w;
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h8; pwdata[1] = 32'h12345678;
        @(posedge clk); #1 penable[1] = 1'b1;
        @(posedge clk); #1;
        checks++; if (pready[1] !== 1'b1) begin errors++; $display("FAIL rstmid_pready_before got %b want 1", pready[1]); end
        preset = 1'b1;
        #1;
        checks++; if (pready[1] !== 1'b0) begin errors++; $display("FAIL rstmid_pready got %b want 0", pready[1]); end
        checks++; if (prdata[1] !== 32'h0) begin errors++; $display("FAIL rstmid_prdata got %h want 0", prdata[1]); end
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1 preset = 1'b0;
        clear_model();
        xfer(1, 1'b0, 32'h8, 32'h0, rd, se, w, af);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_dropped got %h want 0", rd); end
        xfer(1, 1'b0, 32'h10, 32'h0, rd, se, w, af);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_cleared got %h want 0", rd); end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
        end
        test_reset();
        test_basic();
        test_zero_wait();
        test_wait3();
        test_error();
        test_idle_penable();
        test_abort();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
